phase_diff_wrap: RTL

//  Upstream feeder of the phase-to-speed averager. Takes the per-sample carrier

---
 rtl/phase_diff_wrap_if.sv | 12 +
 rtl/phase_diff_wrap.sv | 101 ++++++++++
 2 files changed

// File: rtl/phase_diff_wrap_if.sv
// rtl/phase_diff_wrap_if.sv - phase sample in / wrapped phase difference out bundle
interface phase_diff_wrap_if #(
  parameter int PW = 14
);
  logic                 in_valid;
  logic signed [PW-1:0] in_phase;
  logic signed [18:0]   out_phasediff;
  logic                 data_rdy;

  modport master (output in_valid, in_phase, input out_phasediff, data_rdy);
  modport slave  (input in_valid, in_phase, output out_phasediff, data_rdy);
endinterface

// File: rtl/phase_diff_wrap.sv
// rtl/phase_diff_wrap.sv - lagged carrier phase difference wrapped to (-pi, pi], 9Q10 out
module phase_diff_wrap #(
  parameter int PW     = 14,
  parameter int LAG    = 1,
  parameter int PI_Q10 = 3217
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  phase_diff_wrap_if.slave bus,
  output logic             primed,
  output logic             range_err
);

  localparam int DW = PW + 1;
  localparam logic signed [PW-1:0] PI_P   = PW'(PI_Q10);
  localparam logic signed [DW-1:0] PI_D   = DW'(PI_Q10);
  localparam logic signed [DW-1:0] TWO_PI = DW'(2 * PI_Q10);
  localparam logic [3:0]           LAST   = 4'(LAG - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cnt;
  logic signed [PW-1:0] dl [LAG];
  logic signed [PW-1:0] p;
  logic                 over, under;
  logic                 shift, emit;
  logic signed [DW-1:0] d_raw, d_wrap;

  always_comb begin
    over  = bus.in_phase > PI_P;
    under = bus.in_phase < -PI_P;
    if (over)       p = PI_P;
    else if (under) p = -PI_P;
    else            p = bus.in_phase;
  end

  // |d_raw| <= 2*pi, so a single +/-2*pi correction always lands in (-pi, pi]
  always_comb begin
    d_raw = {p[PW-1], p} - {dl[LAG-1][PW-1], dl[LAG-1]};
    if (d_raw > PI_D)        d_wrap = d_raw - TWO_PI;
    else if (d_raw <= -PI_D) d_wrap = d_raw + TWO_PI;
    else                     d_wrap = d_raw;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    emit      = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_FILL;
        S_FILL: begin
          if (bus.in_valid) begin
            shift = 1'b1;
            if (cnt == LAST) state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.in_valid) begin
            shift = 1'b1;
            emit  = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAG; i++) dl[i] <= '0;
      cnt               <= '0;
      bus.out_phasediff <= '0;
      bus.data_rdy      <= 1'b0;
      range_err         <= 1'b0;
    end else begin
      bus.data_rdy <= emit;
      if (emit) bus.out_phasediff <= {{(19 - DW){d_wrap[DW-1]}}, d_wrap};
      if (shift) begin
        for (int i = LAG - 1; i > 0; i--) dl[i] <= dl[i-1];
        dl[0] <= p;
      end
      // history is only counted while filling; leaving FILL or idling empties it
      if (!enable || state != S_FILL) cnt <= '0;
      else if (shift)                 cnt <= cnt + 4'd1;
      if (bus.in_valid && (over || under)) range_err <= 1'b1;
    end
  end

  assign primed = (state == S_RUN);

endmodule
